// File: rtl/prbs_gen_multi_if.sv
// ============================================================================
// prbs_gen_multi_if : control/data bundle for the multi-polynomial PRBS gen
// Revision 1.0
// ============================================================================
`default_nettype none

interface prbs_gen_multi_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              en;
  logic [1:0]        prbs_sel;
  logic              seed_load;
  logic [30:0]       seed;
  logic              inject_err;
  logic [DATA_W-1:0] prbs_out;
  logic              prbs_valid;
  logic              sof;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output en, prbs_sel, seed_load, seed, inject_err,
    input  prbs_out, prbs_valid, sof, err_cnt
  );

  modport slave (
    input  en, prbs_sel, seed_load, seed, inject_err,
    output prbs_out, prbs_valid, sof, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/prbs_gen_multi.sv
// ============================================================================
// prbs_gen_multi : PRBS7/15/23/31 word generator with seed, inject and framing
// Revision 1.0
// ============================================================================
`default_nettype none

module prbs_gen_multi #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  wire logic        clk1280,
  input  wire logic        rst_n,
  prbs_gen_multi_if.slave  bus
);

  localparam int          FC_W     = $clog2(FRAME_LEN);
  localparam logic [30:0] ALL_ONES = 31'h7FFF_FFFF;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [30:0]       state;
  logic [30:0]       next_state;
  logic [1:0]        sel_q;
  logic [FC_W-1:0]   frame_cnt;
  logic              pending;
  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic              sof_q;
  logic [CNT_W-1:0]  err_q;

  logic [30:0]       mask_q;
  logic [30:0]       seed_masked;
  logic [4:0]        hi_idx;
  logic [4:0]        tap_idx;
  logic [30:0]       s;
  logic              nb;
  logic [DATA_W-1:0] word;
  logic              emit;
  logic              flip;

  function automatic logic [30:0] poly_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    poly_mask = 31'h0000_007F;
      2'd1:    poly_mask = 31'h0000_7FFF;
      2'd2:    poly_mask = 31'h007F_FFFF;
      default: poly_mask = ALL_ONES;
    endcase
  endfunction

  // Reset asserts asynchronously but releases only after two clean clock edges.
  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_comb begin
    mask_q = poly_mask(sel_q);
    case (sel_q)
      2'd0:    begin hi_idx = 5'd6;  tap_idx = 5'd5;  end
      2'd1:    begin hi_idx = 5'd14; tap_idx = 5'd13; end
      2'd2:    begin hi_idx = 5'd22; tap_idx = 5'd17; end
      default: begin hi_idx = 5'd30; tap_idx = 5'd27; end
    endcase
  end

  // DATA_W serial steps unrolled; the first generated bit lands in the MSB.
  always_comb begin
    s    = state;
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      nb = s[hi_idx] ^ s[tap_idx];
      s  = {s[29:0], nb} & mask_q;
      word[DATA_W-1-i] = nb;
    end
    next_state = s;
  end

  assign seed_masked = bus.seed & poly_mask(bus.prbs_sel);
  assign emit        = bus.en && !bus.seed_load && (bus.prbs_sel == sel_q);
  assign flip        = pending | bus.inject_err;

  always_ff @(posedge clk1280 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ALL_ONES;
      sel_q     <= 2'd0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      valid_q <= emit;
      sof_q   <= emit && (frame_cnt == '0);

      if (bus.seed_load) begin
        state     <= (seed_masked == 31'd0) ? ALL_ONES : seed_masked;
        frame_cnt <= '0;
        sel_q     <= bus.prbs_sel;
      end else if (bus.prbs_sel != sel_q) begin
        state     <= ALL_ONES;
        frame_cnt <= '0;
        sel_q     <= bus.prbs_sel;
      end else if (bus.en) begin
        state     <= next_state;
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
      end

      // Corruption touches only the output word, never the LFSR state.
      if (emit) begin
        out_q   <= word ^ DATA_W'(flip);
        pending <= 1'b0;
        if (flip && (err_q != {CNT_W{1'b1}})) err_q <= err_q + CNT_W'(1);
      end else if (bus.inject_err) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.prbs_out   = out_q;
  assign bus.prbs_valid = valid_q;
  assign bus.sof        = sof_q;
  assign bus.err_cnt    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs_gen_multi.sv
// ============================================================================
// tb_prbs_gen_multi : directed self-checking bench for prbs_gen_multi
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prbs_gen_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prbs_gen_multi_if #(.DATA_W(16), .CNT_W(16)) bus ();

  prbs_gen_multi #(.DATA_W(16), .FRAME_LEN(4), .CNT_W(16)) dut (
    .clk1280 (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [30:0] g_s;
  int          g_n;
  int          g_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int n, input int t, input logic [30:0] seed);
    logic [30:0] m;
    m   = (n == 31) ? 31'h7FFF_FFFF : ((31'd1 << n) - 31'd1);
    g_n = n;
    g_t = t;
    g_s = seed & m;
    if (g_s == 31'd0) g_s = m;
  endtask

  // Reference: one bit at a time, shifted in from the right so the first bit ends in the MSB.
  task automatic model_word(output logic [15:0] w);
    logic b;
    w = 16'h0;
    for (int i = 0; i < 16; i++) begin
      b   = g_s[g_n-1] ^ g_s[g_t-1];
      g_s = {g_s[29:0], b};
      w   = {w[14:0], b};
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.prbs_sel = 2'd0; bus.seed_load = 1'b0;
    bus.seed = 31'd0; bus.inject_err = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.prbs_out !== 16'h0) begin errors++; $display("FAIL reset_out: got %h expected 0000", bus.prbs_out); end
    checks++; if (bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.prbs_valid); end
    checks++; if (bus.sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", bus.sof); end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", bus.err_cnt); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", bus.prbs_valid); end
  endtask

  task automatic test_prbs7();
    logic [15:0] exp;
    model_reset(7, 6, 31'd0);
    bus.prbs_sel = 2'd0;
    bus.en = 1'b1;
    for (int i = 0; i < 130; i++) begin
      step();
      model_word(exp);
      checks++;
      if (bus.prbs_valid !== 1'b1 || bus.prbs_out !== exp) begin
        errors++; $display("FAIL prbs7_word%0d: got %h valid %b expected %h valid 1", i, bus.prbs_out, bus.prbs_valid, exp);
      end
      checks++;
      if (bus.sof !== ((i % 4) == 0)) begin errors++; $display("FAIL prbs7_sof%0d: got %b expected %b", i, bus.sof, (i % 4) == 0); end
      if (i == 0 || i == 127) begin
        checks++; if (bus.prbs_out !== 16'h020C) begin errors++; $display("FAIL prbs7_hand%0d: got %h expected 020c", i, bus.prbs_out); end
      end
    end
    bus.en = 1'b0;
    step();
    checks++;
    if (bus.prbs_valid !== 1'b0 || bus.prbs_out !== exp) begin
      errors++; $display("FAIL prbs7_stall: got %h valid %b expected %h valid 0", bus.prbs_out, bus.prbs_valid, exp);
    end
  endtask

  task automatic test_prbs31_seed0();
    logic [15:0] exp;
    int run;
    int max_run;
    bus.prbs_sel = 2'd3; bus.seed_load = 1'b1; bus.seed = 31'd0; bus.en = 1'b1;
    step();
    bus.seed_load = 1'b0;
    checks++; if (bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL p31_load_bubble: got %b expected 0", bus.prbs_valid); end
    model_reset(31, 28, 31'd0);
    run = 0; max_run = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      model_word(exp);
      checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL p31_word%0d: got %h expected %h", i, bus.prbs_out, exp); end
      checks++; if (bus.sof !== (i == 0)) begin errors++; $display("FAIL p31_sof%0d: got %b expected %b", i, bus.sof, i == 0); end
      if (i == 0) begin checks++; if (bus.prbs_out !== 16'h0000) begin errors++; $display("FAIL p31_hand0: got %h expected 0000", bus.prbs_out); end end
      if (i == 1) begin checks++; if (bus.prbs_out !== 16'h000E) begin errors++; $display("FAIL p31_hand1: got %h expected 000e", bus.prbs_out); end end
      for (int b = 15; b >= 0; b--) begin
        run = (bus.prbs_out[b] === 1'b0) ? run + 1 : 0;
        if (run > max_run) max_run = run;
      end
    end
    checks++; if (max_run >= 31) begin errors++; $display("FAIL p31_zero_run: got %0d expected below 31", max_run); end
  endtask

  task automatic test_inject();
    logic [15:0] exp;
    bus.prbs_sel = 2'd0; bus.seed_load = 1'b1; bus.seed = 31'h7FFF_FF7F; bus.en = 1'b1;
    step();
    bus.seed_load = 1'b0;
    model_reset(7, 6, 31'h7FFF_FF7F);
    for (int i = 0; i < 13; i++) begin
      bus.inject_err = (i == 10);
      step();
      model_word(exp);
      if (i == 10) exp[0] = ~exp[0];
      checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL inject_word%0d: got %h expected %h", i, bus.prbs_out, exp); end
    end
    bus.inject_err = 1'b0;
    checks++; if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL inject_cnt1: got %0d expected 1", bus.err_cnt); end
    bus.en = 1'b0; bus.inject_err = 1'b1;
    step();
    step();
    checks++; if (bus.err_cnt !== 16'd1 || bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL inject_pending_hold: got cnt %0d valid %b expected cnt 1 valid 0", bus.err_cnt, bus.prbs_valid); end
    bus.inject_err = 1'b0; bus.en = 1'b1;
    step();
    model_word(exp);
    exp[0] = ~exp[0];
    checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL inject_pending_word: got %h expected %h", bus.prbs_out, exp); end
    step();
    model_word(exp);
    checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL inject_after_word: got %h expected %h", bus.prbs_out, exp); end
    checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL inject_cnt2: got %0d expected 2", bus.err_cnt); end
  endtask

  task automatic test_frame_stall();
    logic [15:0] pattern;
    logic [15:0] exp;
    logic [15:0] last;
    int cnt;
    pattern = 16'b1011_0011_1011_1110;
    bus.prbs_sel = 2'd0; bus.seed_load = 1'b1; bus.seed = 31'h55; bus.en = 1'b0;
    step();
    bus.seed_load = 1'b0;
    checks++; if (bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL frame_load_bubble: got %b expected 0", bus.prbs_valid); end
    model_reset(7, 6, 31'h55);
    cnt = 0;
    last = 16'h0;
    for (int i = 0; i < 16; i++) begin
      bus.en = pattern[15-i];
      step();
      if (pattern[15-i]) begin
        model_word(exp);
        last = exp;
        checks++; if (bus.prbs_valid !== 1'b1 || bus.prbs_out !== exp) begin errors++; $display("FAIL frame_word%0d: got %h valid %b expected %h valid 1", i, bus.prbs_out, bus.prbs_valid, exp); end
        checks++; if (bus.sof !== ((cnt % 4) == 0)) begin errors++; $display("FAIL frame_sof%0d: got %b expected %b", i, bus.sof, (cnt % 4) == 0); end
        cnt++;
      end else begin
        checks++; if (bus.prbs_valid !== 1'b0 || bus.sof !== 1'b0 || bus.prbs_out !== last) begin errors++; $display("FAIL frame_idle%0d: got %h valid %b sof %b expected %h valid 0 sof 0", i, bus.prbs_out, bus.prbs_valid, bus.sof, last); end
      end
    end
  endtask

  task automatic test_sel_switch();
    logic [15:0] exp;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      model_word(exp);
      checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL sel_pre%0d: got %h expected %h", i, bus.prbs_out, exp); end
    end
    bus.prbs_sel = 2'd3;
    step();
    checks++; if (bus.prbs_valid !== 1'b0) begin errors++; $display("FAIL sel_bubble: got %b expected 0", bus.prbs_valid); end
    model_reset(31, 28, 31'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      model_word(exp);
      checks++; if (bus.prbs_valid !== 1'b1 || bus.prbs_out !== exp) begin errors++; $display("FAIL sel_post%0d: got %h valid %b expected %h valid 1", i, bus.prbs_out, bus.prbs_valid, exp); end
      checks++; if (bus.sof !== (i == 0)) begin errors++; $display("FAIL sel_sof%0d: got %b expected %b", i, bus.sof, i == 0); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    bus.prbs_sel = 2'd0; bus.en = 1'b1;
    repeat (3) step();
    bus.en = 1'b0; bus.inject_err = 1'b1;
    step();
    bus.inject_err = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.prbs_out !== 16'h0 || bus.prbs_valid !== 1'b0 || bus.sof !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got %h valid %b sof %b expected 0000 0 0", bus.prbs_out, bus.prbs_valid, bus.sof); end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL midrst_errcnt: got %0d expected 0", bus.err_cnt); end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    model_reset(7, 6, 31'd0);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      model_word(exp);
      checks++; if (bus.prbs_out !== exp) begin errors++; $display("FAIL midrst_word%0d: got %h expected %h", i, bus.prbs_out, exp); end
      checks++; if (bus.sof !== (i == 0)) begin errors++; $display("FAIL midrst_sof%0d: got %b expected %b", i, bus.sof, i == 0); end
      if (i == 0) begin checks++; if (bus.prbs_out !== 16'h020C) begin errors++; $display("FAIL midrst_hand0: got %h expected 020c", bus.prbs_out); end end
    end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL midrst_no_inject: got %0d expected 0", bus.err_cnt); end
    bus.en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prbs7();
    test_prbs31_seed0();
    test_inject();
    test_frame_stall();
    test_sel_switch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
